// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a skid buffer: a main register drives the outputs, and one skid entry absorbs a stall.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 10,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [ADDR_W-1:0] out_rd,
`ifdef PIPE_STAGE_PERF_EN
    output logic [1:0]        count,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`else
    output logic [1:0]        count
`endif
);

    // Valid/ready: a word moves on a rising edge when valid and ready are both high.
    // The producer must not withdraw or change a word while it waits for ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic accept;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [ADDR_W-1:0] main_rd,   skid_rd;

    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // in_ready is a flop of the next state, so it never depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
            main_ctrl <= '0;
            main_rd   <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            skid_rd   <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
                main_rd   <= in_rd;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
                main_rd   <= skid_rd;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
                skid_rd   <= in_rd;
            end
        end
    end

    // Bubbles present a NOP: control and destination are zeroed whenever nothing is valid.
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_rd    = out_valid ? main_rd   : '0;
    assign count     = state;

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
            if (flush && (state != EMPTY)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: the driver pushes accepted words into exp_q, and a monitor pops and compares every output transfer.
// Define PIPE_STAGE_PERF_EN to also exercise the performance counters.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 10;
    localparam int ADDR_W = 5;
    localparam int W      = DATA_W + CTRL_W + ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [ADDR_W-1:0] in_rd;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [ADDR_W-1:0] out_rd;
    logic [1:0]        count;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
`endif

    logic [W-1:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;
    bit stream_done = 1'b0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_rd     (in_rd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_rd    (out_rd),
`ifdef PIPE_STAGE_PERF_EN
        .count     (count),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`else
        .count     (count)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Driver: hold the word until accepted, then record what the DUT must emit.
    task automatic send(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic [ADDR_W-1:0] r, output int waits);
        bit done;
        done     = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        in_rd    = r;
        while (!done) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                exp_q.push_back({r, c, d});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waits++;
                if (waits > 200) begin
                    n_total++;
                    $display("FAIL send_timeout: got no in_ready after %0d cycles expected acceptance", waits);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_out: got 0x%0h expected no output", {out_rd, out_ctrl, out_data});
                end else begin
                    check("out_payload", 64'({out_rd, out_ctrl, out_data}), 64'(exp_q.pop_front()));
                end
            end else if (rst_n === 1'b1 && !out_valid) begin
                check("bubble_ctrl", 64'(out_ctrl), 64'd0);
                check("bubble_rd",   64'(out_rd),   64'd0);
            end
        end
    end

    initial begin
        int w;
        int stalls;
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        in_rd     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset values
        #12;
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count",     64'(count),     64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        check("rst_out_rd",    64'(out_rd),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", 64'(in_ready), 64'd0);
        tick(1);
        check("in_ready_after_edge", 64'(in_ready), 64'd1);

        // One-cycle latency from EMPTY
        out_ready = 1'b1;
        send(32'h1234, 10'h3FF, 5'd7, w);
        in_valid = 1'b0;
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("lat_out_data",  64'(out_data),  64'h1234);
        check("lat_out_ctrl",  64'(out_ctrl),  64'h3FF);
        check("lat_count",     64'(count),     64'd1);
        tick(1);
        check("lat_drained", 64'(count), 64'd0);

        // Fill to FULL under stall, hold, then drain in order
        out_ready = 1'b0;
        send(32'h11, 10'h1, 5'd1, w);
        send(32'h22, 10'h2, 5'd2, w);
        in_valid = 1'b0;
        check("full_count",    64'(count),    64'd2);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head",     64'(out_data), 64'h11);
        tick(3);
        check("stall_hold_data", 64'(out_data), 64'h11);
        check("stall_hold_ctrl", 64'(out_ctrl), 64'h1);
        check("stall_hold_rd",   64'(out_rd),   64'd1);
        out_ready = 1'b1;
        tick(1);
        check("drain_second", 64'(out_data), 64'h22);
        check("drain_count",  64'(count),    64'd1);
        check("drain_ready",  64'(in_ready), 64'd1);
        tick(1);
        check("drain_empty", 64'(out_valid), 64'd0);

        // Flush while FULL with a word offered
        out_ready = 1'b0;
        send(32'hA1, 10'h11, 5'd11, w);
        send(32'hB2, 10'h12, 5'd12, w);
        in_valid = 1'b1;
        in_data  = 32'h33;
        in_ctrl  = 10'h3;
        in_rd    = 5'd3;
        flush    = 1'b1;
        tick(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_full_count",    64'(count),     64'd0);
        check("flush_full_valid",    64'(out_valid), 64'd0);
        check("flush_full_ctrl",     64'(out_ctrl),  64'd0);
        check("flush_full_rd",       64'(out_rd),    64'd0);
        check("flush_full_in_ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        tick(3);

        // Flush in ONE discards a same-cycle accepted word
        out_ready = 1'b0;
        send(32'h55, 10'h5, 5'd5, w);
        in_valid = 1'b1;
        in_data  = 32'h44;
        in_ctrl  = 10'h4;
        in_rd    = 5'd4;
        flush    = 1'b1;
        tick(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_one_count", 64'(count), 64'd0);
        out_ready = 1'b1;
        tick(3);

        // Flush together with an output transfer: the word is still delivered
        out_ready = 1'b0;
        send(32'h66, 10'h6, 5'd6, w);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush_fire_delivered", 64'(exp_q.size()), 64'd0);
        check("flush_fire_count",     64'(count),        64'd0);

        // Asynchronous reset pulse between edges while FULL
        out_ready = 1'b0;
        send(32'h77, 10'h7, 5'd8, w);
        send(32'h88, 10'h8, 5'd9, w);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_count",     64'(count),     64'd0);
        check("arst_out_data",  64'(out_data),  64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd0);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        tick(1);
        check("arst_in_ready_post", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick(3);

        // Stream 100 incrementing words against a random 50% out_ready
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    send(DATA_W'(32'h100 + i), CTRL_W'(i), ADDR_W'(i), w);
                end
                in_valid    = 1'b0;
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            tick(1);
            k++;
        end
        check("stream_drain", 64'(exp_q.size()), 64'd0);

        // Sustained one-per-cycle throughput with out_ready held high
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send(DATA_W'(32'hC00 + i), CTRL_W'(i + 1), ADDR_W'(i + 2), w);
            stalls += w;
        end
        in_valid = 1'b0;
        check("throughput_waits", 64'(stalls), 64'd0);
        tick(2);

`ifdef PIPE_STAGE_PERF_EN
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check("perf_stall_rst", 64'(stall_cnt), 64'd0);
        check("perf_flush_rst", 64'(flush_cnt), 64'd0);
        out_ready = 1'b0;
        send(32'h99, 10'h9, 5'd10, w);
        in_valid = 1'b0;
        tick(7);
        check("perf_stall_7", 64'(stall_cnt), 64'd7);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        exp_q.delete();
        check("perf_flush_1", 64'(flush_cnt), 64'd1);
        out_ready = 1'b1;
        tick(2);
`endif

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the datapath payload (ALU result, store data, PC+4, etc.).
REQ-002 SHALL have parameter CTRL_W, default 10: width of the control payload, e.g. MemRead/MemWrite/Load/Store/MemtoReg/RegWrite.
REQ-003 SHALL have parameter ADDR_W, default 5: width of the destination register address.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream stage presents a valid instruction.
REQ-007 in_ready  output  1  stage can accept; registered, not combinational from out_ready.
REQ-008 in_data  input  DATA_W  datapath payload.
REQ-009 in_ctrl  input  CTRL_W  control payload.
REQ-010 in_rd  input  ADDR_W  destination register address.
REQ-011 flush  input  1  synchronous kill of all held instructions.
REQ-012 out_valid  output  1  downstream payload valid.
REQ-013 out_ready  input  1  downstream accepts (0 = stall).
REQ-014 out_data, out_ctrl, out_rd  output  DATA_W/CTRL_W/ADDR_W  registered payload.
REQ-015 count  output  2  occupancy, 0..2.

Function
REQ-016 Transfer in SHALL occur when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-017 Storage SHALL be a main register driving outputs plus one skid register; states EMPTY (count 0), ONE (count 1), FULL (count 2).
REQ-018 EMPTY: accept -> ONE, payload into main; otherwise stay.
REQ-019 ONE: accept & out fire -> ONE, main reloaded from input; accept & no out fire -> FULL, input into skid; out fire only -> EMPTY; neither -> stay.
REQ-020 FULL: in_ready SHALL be 0; out fire -> ONE, skid moves to main; otherwise stay.
REQ-021 in_ready SHALL equal 1 in EMPTY and ONE, 0 in FULL, registered from next state.
REQ-022 Latency input to output SHALL be exactly 1 cycle when EMPTY and out_ready=1; throughput 1/cycle sustained.
REQ-023 Order SHALL be preserved; no instruction duplicated or dropped except by flush.
REQ-024 While out_valid=1 and out_ready=0, out_data/out_ctrl/out_rd SHALL hold stable.
REQ-025 flush SHALL have priority over every other event: next state EMPTY, count 0, any same-cycle input transfer discarded.
REQ-026 When out_valid=0, out_ctrl and out_rd SHALL read 0 (bubble is a NOP); out_data MAY hold stale value.
REQ-027 Flush and simultaneous out fire SHALL still count as one out fire for the downstream; the stage is empty next cycle.

Reset
REQ-028 rst_n low SHALL immediately force state EMPTY, count=0, out_valid=0, out_data=0, out_ctrl=0, out_rd=0, skid contents 0.
REQ-029 in_ready SHALL read 0 while rst_n is low and 1 from the first rising edge after deassertion.
REQ-030 Reset asserted mid-transfer SHALL discard all held payloads; no partial payload SHALL appear at outputs.

Configuration
REQ-031 Macro PIPE_STAGE_PERF_EN SHALL gate performance counters.
REQ-032 With PIPE_STAGE_PERF_EN defined: outputs stall_cnt[31:0] (increments each cycle out_valid & !out_ready) and flush_cnt[31:0] (increments each cycle flush kills count>0), both wrap at 2^32, reset to 0.
REQ-033 Without it: the ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-034 Reset, then in_valid=1 in_data=0x1234 in_ctrl=0x3FF, out_ready=1 -> next cycle out_valid=1 out_data=0x1234, count=1.
REQ-035 out_ready=0, push A=0x11, B=0x22 -> count=2, in_ready=0, out_data=0x11 stable; raise out_ready -> 0x11 then 0x22 on consecutive cycles.
REQ-036 FULL with A,B, flush=1 with in_valid=1 C=0x33 -> next cycle count=0, out_valid=0, out_ctrl=0, out_rd=0; C never emitted.
REQ-037 Streaming 100 incrementing words, out_ready random 50% -> output sequence identical to input, no gaps when out_ready=1 and count>0.
REQ-038 rst_n pulsed low between edges while count=2 -> out_valid=0 and count=0 before next edge, in_ready=1 after first edge post-release.
REQ-039 With PIPE_STAGE_PERF_EN, hold out_ready=0 for 7 cycles with out_valid=1 -> stall_cnt=7; one flush while count=1 -> flush_cnt=1.
